apb_rr_master_arbiter: RTL and testbench

//  Shares one APB master port between NREQ local requesters using round-robin arbitration.

---
 rtl/apb_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/apb_rr_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the round-robin APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned DefaultAw = 4;
  localparam int unsigned DefaultDw = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  int unsigned j;

  always_comb begin
    any     = 1'b0;
    win     = '0;
    win_idx = '0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Define APB_TIMEOUT_EN to force-complete stalled ACCESS phases after TO_CYC cycles.
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AW     = DefaultAw,
  parameter int unsigned DW     = DefaultDw,
  parameter int unsigned TO_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic             pready,
  input  logic [DW-1:0]    prdata,
  input  logic             pslverr
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TO_CYC < 1) begin : g_bad_params
    $error("apb_rr_master_arbiter: NREQ must be 2..8 and TO_CYC at least 1");
  end

  apb_state_t      state_q;
  logic [IW-1:0]   ptr_q, gidx_q, ptr_next;
  logic [NREQ-1:0] gnt_q, done_q;
  logic            err_q, psel_q, penable_q, pwrite_q;
  logic [DW-1:0]   rdata_q, pwdata_q;
  logic [AW-1:0]   paddr_q;

  logic            pick_any;
  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            timeout, finish;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [CW-1:0] wait_q;
  assign timeout = (wait_q == CW'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign finish   = (state_q == ACCESS) && (pready || timeout);
  assign ptr_next = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q    <= pick_win;
            gidx_q   <= pick_idx;
            pwrite_q <= req_wr[pick_idx];
            paddr_q  <= req_addr[pick_idx*AW +: AW];
            pwdata_q <= req_wdata[pick_idx*DW +: DW];
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ACCESS: begin
          if (finish) begin
            done_q    <= gnt_q;
            // A timeout reports an error and leaves rdata untouched.
            err_q     <= pready ? pslverr : 1'b1;
            if (pready && !pwrite_q) rdata_q <= prdata;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt_q     <= '0;
            ptr_q     <= ptr_next;
            state_q   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            wait_q <= wait_q + CW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_apb_rr_master_arbiter;

  localparam int NREQ   = 4;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    gnt, done;
  logic               err, psel, penable, pwrite;
  logic [DW-1:0]      rdata, pwdata;
  logic [AW-1:0]      paddr;
  logic               pready = 1'b1;
  logic [DW-1:0]      prdata = '0;
  logic               pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  apb_rr_master_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done == '0 && n < limit) begin
      step();
      n++;
    end
    check("wait_done_in_time", done != '0, 1);
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Transaction-level model: one transfer in flight, tracked as winner plus phase flags.
  bit            m_busy, m_acc, m_wr, m_err;
  int            m_win, m_ptr, m_stalls;
  logic [NREQ-1:0] m_done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            pick;
  bit            m_timed_out;

  assign pick = rr_winner(req, m_ptr);
`ifdef APB_TIMEOUT_EN
  assign m_timed_out = (m_stalls + 1 >= TO_CYC);
`else
  assign m_timed_out = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_acc <= 0; m_wr <= 0; m_err <= 0; m_win <= 0; m_ptr <= 0;
      m_stalls <= 0; m_done <= '0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else begin
      m_done <= '0;
      m_err  <= 0;
      if (!m_busy) begin
        if (pick >= 0) begin
          m_busy  <= 1;
          m_acc   <= 0;
          m_win   <= pick;
          m_wr    <= req_wr[pick];
          m_addr  <= req_addr[pick*AW +: AW];
          m_wdata <= req_wdata[pick*DW +: DW];
        end
      end else if (!m_acc) begin
        m_acc    <= 1;
        m_stalls <= 0;
      end else if (pready || m_timed_out) begin
        m_done <= NREQ'(1) << m_win;
        m_err  <= pready ? pslverr : 1'b1;
        if (pready && !m_wr) m_rdata <= prdata;
        m_ptr  <= (m_win + 1) % NREQ;
        m_busy <= 0;
        m_acc  <= 0;
      end else begin
        m_stalls <= m_stalls + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("psel", psel, m_busy);
      check("penable", penable, m_busy && m_acc);
      check("gnt", gnt, m_busy ? (32'd1 << m_win) : 32'd0);
      check("done", done, m_done);
      if (m_done != '0) check("err", err, m_err);
      check("rdata", rdata, m_rdata);
      check("pwrite", pwrite, m_wr);
      check("paddr", paddr, m_addr);
      check("pwdata", pwdata, m_wdata);
    end
  end

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int order[$];
  logic [NREQ-1:0] prev_gnt;
  logic [NREQ-1:0] first_gnt;
  int n_acc;

  initial begin
    // Reset held with every requester asking
    req = 4'b1111;
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_psel", psel, 0);
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_rdata", rdata, 0);
    end
    rst = 1'b0;
    req = '0;
    step();

    // Single write from requester 2
    req_wr[2] = 1'b1;
    req_addr[2*AW +: AW] = 4'h5;
    req_wdata[2*DW +: DW] = 8'hA5;
    pready = 1'b1;
    req[2] = 1'b1;
    step();
    check("t2_gnt", gnt, 4'b0100);
    check("t2_psel", psel, 1);
    check("t2_penable_setup", penable, 0);
    step();
    check("t2_penable", penable, 1);
    check("t2_paddr", paddr, 4'h5);
    check("t2_pwdata", pwdata, 8'hA5);
    check("t2_pwrite", pwrite, 1);
    step();
    check("t2_done", done, 4'b0100);
    req[2] = 1'b0;
    step();
    check("t2_done_clear", done, 0);
    check("t2_psel_idle", psel, 0);

    // Read with two wait states
    req_wr[0] = 1'b0;
    req_addr[0 +: AW] = 4'h3;
    pready = 1'b0;
    req[0] = 1'b1;
    step();
    check("t3_gnt", gnt, 4'b0001);
    step();
    check("t3_penable", penable, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t3_psel_hold", psel, 1);
      check("t3_penable_hold", penable, 1);
      check("t3_paddr_hold", paddr, 4'h3);
      check("t3_no_done", done, 0);
    end
    pready = 1'b1;
    prdata = 8'h3C;
    step();
    check("t3_done", done, 4'b0001);
    check("t3_rdata", rdata, 8'h3C);
    check("t3_err", err, 0);
    req[0] = 1'b0;
    prdata = '0;
    step();

    // Fairness with all requesters held high from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_wr = '0;
    req = 4'b1111;
    prev_gnt = '0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step();
      check("t4_done_onehot", $countones(done) <= 1, 1);
      if (gnt != '0 && prev_gnt == '0) order.push_back(oh_idx(gnt));
      prev_gnt = gnt;
    end
    req = '0;
    check("t4_grant_count", order.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check("t4_grant_order", order[i], exp_order[i]);
    end
    repeat (5) step();

    // Slave error, then reset abort during ACCESS
    req_wr[1] = 1'b1;
    req_addr[1*AW +: AW] = 4'h9;
    req_wdata[1*DW +: DW] = 8'h5A;
    pslverr = 1'b1;
    pready = 1'b1;
    req[1] = 1'b1;
    wait_done(10);
    check("t5_done", done, 4'b0010);
    check("t5_err", err, 1);
    req[1] = 1'b0;
    pslverr = 1'b0;
    step();
    req_wr[3] = 1'b0;
    req_addr[3*AW +: AW] = 4'hC;
    pready = 1'b0;
    req[3] = 1'b1;
    step();
    check("t5_gnt3", gnt, 4'b1000);
    step();
    step();
    check("t5_in_access", penable, 1);
    rst = 1'b1;
    req_wr[0] = 1'b0;
    req[0] = 1'b1;
    step();
    check("t5_abort_psel", psel, 0);
    check("t5_abort_penable", penable, 0);
    check("t5_abort_gnt", gnt, 0);
    check("t5_abort_done", done, 0);
    rst = 1'b0;
    step();
    check("t5_ptr_reset_gnt", gnt, 4'b0001);
    check("t5_no_done_after_abort", done, 0);
    pready = 1'b1;
    wait_done(10);
    check("t5_done0", done, 4'b0001);
    req[0] = 1'b0;
    step();
    check("t5_gnt3_again", gnt, 4'b1000);
    req[3] = 1'b0;
    wait_done(10);
    check("t5_done3_after_drop", done, 4'b1000);
    step();

`ifdef APB_TIMEOUT_EN
    // Timeout with pready stuck low
    pready = 1'b0;
    req_wr[1:0] = 2'b00;
    req[1:0] = 2'b11;
    for (int i = 0; i < 6 && penable == 1'b0; i++) step();
    check("t6_access_entry", penable, 1);
    first_gnt = gnt;
    n_acc = 0;
    while (done == '0 && n_acc < 40) begin
      step();
      n_acc++;
    end
    check("t6_access_cycles", n_acc, TO_CYC);
    check("t6_done", done, first_gnt);
    check("t6_err", err, 1);
    req = req & ~first_gnt;
    step();
    check("t6_next_gnt", gnt, 4'b0011 & ~first_gnt);
    pready = 1'b1;
    wait_done(10);
    req = '0;
    step();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_wr[i] = 1'($urandom);
          req_addr[i*AW +: AW] = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
          req[i] = 1'b1;
        end
      end
      pready  = ($urandom_range(0, 2) != 0);
      prdata  = DW'($urandom);
      pslverr = ($urandom_range(0, 4) == 0);
    end
    rst = 1'b0;
    req = '0;
    pready = 1'b1;
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
